// File: rtl/xcvr_init_pkg.sv
// Shared types and sizing helpers for the transceiver reference-clock bring-up sequencer.
package xcvr_init_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_TX_REL    = 3'd3,
        S_RX_REL    = 3'd4,
        S_READY     = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam int RETRY_CNT_W = 2;

    // One timer serves every state, so it must reach the largest of the three limits.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/xcvr_init_sync.sv
// Multi-flop synchroniser for one asynchronous status bit.
module xcvr_init_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/xcvr_refclk_init_sequencer.sv
// Brings up the transceiver PLL and lanes: PLL reset, lock wait, settle, TX/RX release,
// with per-state timeouts, bounded retries and a sticky failure state.
module xcvr_refclk_init_sequencer
    import xcvr_init_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   PLL_LOCK,
    input  logic                   TX_CLK_STABLE,
    input  logic                   RX_READY,
    input  logic                   RETRY,
    output logic                   PLL_RESET_N,
    output logic                   TX_RESET_N,
    output logic                   RX_RESET_N,
    output logic                   LINK_READY,
    output logic                   INIT_FAIL,
    output logic [2:0]             STATE,
    output logic [RETRY_CNT_W-1:0] RETRY_CNT
);

    localparam int TW = timer_width(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    state_t                 next_state;
    logic [TW-1:0]          timer;
    logic [RETRY_CNT_W-1:0] retry_cnt;
    logic [RETRY_CNT_W-1:0] next_retry;
    logic                   lock_s;
    logic                   txs_s;
    logic                   rxr_s;
    logic                   timeout;
    logic                   take_timeout;
    logic [4:0]             out_d;
    logic [4:0]             out_q;

    xcvr_init_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk(CLK), .rst_n(RESETN), .d(PLL_LOCK), .q(lock_s)
    );
    xcvr_init_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_txs (
        .clk(CLK), .rst_n(RESETN), .d(TX_CLK_STABLE), .q(txs_s)
    );
    xcvr_init_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rxr (
        .clk(CLK), .rst_n(RESETN), .d(RX_READY), .q(rxr_s)
    );

    assign timeout = (timer == TIMEOUT_LAST);

    // Success conditions are tested before the timeout so they win a same-cycle tie;
    // loss of lock is tested first in every post-lock state.
    always_comb begin
        next_state   = state;
        next_retry   = retry_cnt;
        take_timeout = 1'b0;
        out_d        = 5'b0;

        case (state)
            S_PLL_RST: begin
                if (timer == RST_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s)       next_state   = S_SETTLE;
                else if (timeout) take_timeout = 1'b1;
            end
            S_SETTLE: begin
                if (!lock_s)                   next_state = S_WAIT_LOCK;
                else if (timer == SETTLE_LAST) next_state = S_TX_REL;
            end
            S_TX_REL: begin
                if (!lock_s)      next_state   = S_WAIT_LOCK;
                else if (txs_s)   next_state   = S_RX_REL;
                else if (timeout) take_timeout = 1'b1;
            end
            S_RX_REL: begin
                if (!lock_s)      next_state   = S_WAIT_LOCK;
                else if (rxr_s)   next_state   = S_READY;
                else if (timeout) take_timeout = 1'b1;
            end
            S_READY: begin
                if (!lock_s)     next_state = S_WAIT_LOCK;
                else if (!txs_s) next_state = S_TX_REL;
                else if (!rxr_s) next_state = S_RX_REL;
            end
            S_FAIL: begin
                if (RETRY) begin
                    next_state = S_PLL_RST;
                    next_retry = '0;
                end
            end
            default: next_state = S_PLL_RST;
        endcase

        if (take_timeout) begin
            if (int'(retry_cnt) < MAX_RETRIES) begin
                next_state = S_PLL_RST;
                if (retry_cnt != '1) next_retry = retry_cnt + RETRY_CNT_W'(1);
            end else begin
                next_state = S_FAIL;
            end
        end

        if (next_state == S_READY && state != S_READY) next_retry = '0;

        // {PLL_RESET_N, TX_RESET_N, RX_RESET_N, LINK_READY, INIT_FAIL} for the state being entered
        case (next_state)
            S_WAIT_LOCK, S_SETTLE: out_d = 5'b10000;
            S_TX_REL:              out_d = 5'b11000;
            S_RX_REL:              out_d = 5'b11100;
            S_READY:               out_d = 5'b11110;
            S_FAIL:                out_d = 5'b00001;
            default:               out_d = 5'b00000;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            retry_cnt <= '0;
            out_q     <= '0;
        end else begin
            state     <= next_state;
            retry_cnt <= next_retry;
            out_q     <= out_d;
            if (next_state != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign {PLL_RESET_N, TX_RESET_N, RX_RESET_N, LINK_READY, INIT_FAIL} = out_q;
    assign STATE     = state;
    assign RETRY_CNT = retry_cnt;

endmodule

// File: tb/tb_xcvr_refclk_init_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a randomized run
// compared against a phase/dwell reference model.
module tb_xcvr_refclk_init_sequencer;

    localparam int RST_CYCLES     = 4;
    localparam int SETTLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int MAX_RETRIES    = 2;
    localparam int SYNC_STAGES    = 2;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       PLL_LOCK = 1'b0;
    logic       TX_CLK_STABLE = 1'b0;
    logic       RX_READY = 1'b0;
    logic       RETRY = 1'b0;
    logic       PLL_RESET_N;
    logic       TX_RESET_N;
    logic       RX_RESET_N;
    logic       LINK_READY;
    logic       INIT_FAIL;
    logic [2:0] STATE;
    logic [1:0] RETRY_CNT;

    xcvr_refclk_init_sequencer #(
        .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES(MAX_RETRIES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .TX_CLK_STABLE(TX_CLK_STABLE),
        .RX_READY(RX_READY), .RETRY(RETRY), .PLL_RESET_N(PLL_RESET_N), .TX_RESET_N(TX_RESET_N),
        .RX_RESET_N(RX_RESET_N), .LINK_READY(LINK_READY), .INIT_FAIL(INIT_FAIL),
        .STATE(STATE), .RETRY_CNT(RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase number, cycles spent in it, retries used, delayed input history.
    int m_phase;
    int m_dwell;
    int m_cnt;
    bit lock_q[$];
    bit txs_q[$];
    bit rxr_q[$];
    int released_by_phase[7] = '{0, 1, 1, 2, 3, 3, 0};

    typedef struct {
        string      name;
        bit         lock;
        bit         txs;
        bit         rxr;
        int         cycles;
        logic [2:0] st;
        logic [1:0] cnt;
        bit         pll;
        bit         tx;
        bit         rx;
        bit         link;
        bit         fail;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t make_vec(input string name, input bit lock, input bit txs, input bit rxr,
                                      input int cycles, input logic [2:0] st, input logic [1:0] cnt,
                                      input bit pll, input bit tx, input bit rx, input bit link,
                                      input bit fail);
        vec_t v;
        v.name = name; v.lock = lock; v.txs = txs; v.rxr = rxr; v.cycles = cycles;
        v.st = st; v.cnt = cnt; v.pll = pll; v.tx = tx; v.rx = rx; v.link = link; v.fail = fail;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [2:0] st, input logic [1:0] cnt,
                                input bit pll, input bit tx, input bit rx, input bit link,
                                input bit fail);
        logic [9:0] act;
        logic [9:0] expv;
        act  = {STATE, RETRY_CNT, PLL_RESET_N, TX_RESET_N, RX_RESET_N, LINK_READY, INIT_FAIL};
        expv = {st, cnt, pll, tx, rx, link, fail};
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got state=%0d cnt=%0d pll/tx/rx/link/fail=%b, expected state=%0d cnt=%0d pll/tx/rx/link/fail=%b",
                     name, $time, act[9:7], act[6:5], act[4:0], expv[9:7], expv[6:5], expv[4:0]);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_dwell = 0;
        m_cnt   = 0;
        lock_q  = {};
        txs_q   = {};
        rxr_q   = {};
        repeat (SYNC_STAGES) begin
            lock_q.push_back(1'b0);
            txs_q.push_back(1'b0);
            rxr_q.push_back(1'b0);
        end
    endtask

    // Advances the model by one clock edge using the inputs the DUT samples at that edge.
    task automatic model_step();
        bit l, t, r, tmo;
        int nxt;
        l = lock_q.pop_front();
        t = txs_q.pop_front();
        r = rxr_q.pop_front();
        lock_q.push_back(PLL_LOCK);
        txs_q.push_back(TX_CLK_STABLE);
        rxr_q.push_back(RX_READY);
        tmo = (m_dwell + 1 == TIMEOUT_CYCLES);
        nxt = m_phase;
        case (m_phase)
            0: if (m_dwell + 1 == RST_CYCLES) nxt = 1;
            1: if (l) nxt = 2; else if (tmo) nxt = -1;
            2: if (!l) nxt = 1; else if (m_dwell + 1 == SETTLE_CYCLES) nxt = 3;
            3: if (!l) nxt = 1; else if (t) nxt = 4; else if (tmo) nxt = -1;
            4: if (!l) nxt = 1; else if (r) nxt = 5; else if (tmo) nxt = -1;
            5: if (!l) nxt = 1; else if (!t) nxt = 3; else if (!r) nxt = 4;
            default: if (RETRY) begin nxt = 0; m_cnt = 0; end
        endcase
        if (nxt == -1) begin
            if (m_cnt < MAX_RETRIES) begin
                m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
                nxt = 0;
            end else begin
                nxt = 6;
            end
        end
        if (nxt == 5 && m_phase != 5) m_cnt = 0;
        m_dwell = (nxt != m_phase) ? 0 : m_dwell + 1;
        m_phase = nxt;
    endtask

    task automatic check_model(input string name);
        int rel;
        rel = released_by_phase[m_phase];
        check_output(name, 3'(m_phase), 2'(m_cnt), rel >= 1, rel >= 2, rel >= 3,
                     m_phase == 5, m_phase == 6);
    endtask

    task automatic apply_stimulus(input bit lock, input bit txs, input bit rxr, input bit retry);
        PLL_LOCK      = lock;
        TX_CLK_STABLE = txs;
        RX_READY      = rxr;
        RETRY         = retry;
    endtask

    task automatic step_cycle();
        @(posedge CLK);
        if (RESETN) model_step();
        @(negedge CLK);
    endtask

    // Asserts reset between edges, checks the immediate reset values, releases on a later negedge.
    task automatic do_reset(input bit lock, input bit txs, input bit rxr, input string name);
        RESETN = 1'b0;
        apply_stimulus(lock, txs, rxr, 1'b0);
        model_reset();
        #1;
        check_output(name, 3'd0, 2'd0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    initial begin
        vecs.push_back(make_vec("nom_pll_rst_hold",  1, 1, 1, 3, 3'd0, 2'd0, 0, 0, 0, 0, 0));
        vecs.push_back(make_vec("nom_pll_release",   1, 1, 1, 1, 3'd1, 2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(make_vec("nom_settle_entry",  1, 1, 1, 1, 3'd2, 2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(make_vec("nom_settle_hold",   1, 1, 1, 7, 3'd2, 2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(make_vec("nom_tx_release",    1, 1, 1, 1, 3'd3, 2'd0, 1, 1, 0, 0, 0));
        vecs.push_back(make_vec("nom_rx_release",    1, 1, 1, 1, 3'd4, 2'd0, 1, 1, 1, 0, 0));
        vecs.push_back(make_vec("nom_link_ready",    1, 1, 1, 1, 3'd5, 2'd0, 1, 1, 1, 1, 0));
        vecs.push_back(make_vec("rx_drop_sync",      1, 1, 0, 2, 3'd5, 2'd0, 1, 1, 1, 1, 0));
        vecs.push_back(make_vec("rx_drop_exit",      1, 1, 0, 1, 3'd4, 2'd0, 1, 1, 1, 0, 0));
        vecs.push_back(make_vec("rx_back_sync",      1, 1, 1, 2, 3'd4, 2'd0, 1, 1, 1, 0, 0));
        vecs.push_back(make_vec("rx_back_ready",     1, 1, 1, 1, 3'd5, 2'd0, 1, 1, 1, 1, 0));
        vecs.push_back(make_vec("lock_rx_drop_sync", 0, 1, 0, 2, 3'd5, 2'd0, 1, 1, 1, 1, 0));
        vecs.push_back(make_vec("lock_rx_drop_exit", 0, 1, 0, 1, 3'd1, 2'd0, 1, 0, 0, 0, 0));

        // Nominal bring-up, RX loss/recovery and simultaneous lock+RX loss.
        do_reset(1, 1, 1, "reset_values");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].lock, vecs[i].txs, vecs[i].rxr, 1'b0);
            repeat (vecs[i].cycles) step_cycle();
            check_output(vecs[i].name, vecs[i].st, vecs[i].cnt, vecs[i].pll, vecs[i].tx,
                         vecs[i].rx, vecs[i].link, vecs[i].fail);
        end

        // One-cycle lock glitch in settle coinciding with the settle deadline.
        do_reset(1, 1, 1, "glitch_reset");
        repeat (10) step_cycle();
        check_output("glitch_settle_before", 3'd2, 2'd0, 1, 0, 0, 0, 0);
        PLL_LOCK = 1'b0;
        step_cycle();
        PLL_LOCK = 1'b1;
        step_cycle();
        check_output("glitch_not_seen_yet", 3'd2, 2'd0, 1, 0, 0, 0, 0);
        step_cycle();
        check_output("glitch_lock_lost", 3'd1, 2'd0, 1, 0, 0, 0, 0);
        step_cycle();
        check_output("glitch_relock", 3'd2, 2'd0, 1, 0, 0, 0, 0);
        repeat (7) step_cycle();
        check_output("glitch_settle_full", 3'd2, 2'd0, 1, 0, 0, 0, 0);
        step_cycle();
        check_output("glitch_tx_release", 3'd3, 2'd0, 1, 1, 0, 0, 0);

        // Lock never arrives: two retried timeouts, then failure, then RETRY restarts.
        do_reset(0, 1, 1, "timeout_reset");
        repeat (35) step_cycle();
        check_output("tmo1_edge_minus1", 3'd1, 2'd0, 1, 0, 0, 0, 0);
        step_cycle();
        check_output("tmo1_retry", 3'd0, 2'd1, 0, 0, 0, 0, 0);
        repeat (35) step_cycle();
        check_output("tmo2_edge_minus1", 3'd1, 2'd1, 1, 0, 0, 0, 0);
        step_cycle();
        check_output("tmo2_retry", 3'd0, 2'd2, 0, 0, 0, 0, 0);
        repeat (35) step_cycle();
        check_output("tmo3_edge_minus1", 3'd1, 2'd2, 1, 0, 0, 0, 0);
        step_cycle();
        check_output("fail_entry", 3'd6, 2'd2, 0, 0, 0, 0, 1);
        repeat (3) step_cycle();
        check_output("fail_sticky", 3'd6, 2'd2, 0, 0, 0, 0, 1);
        RETRY = 1'b1;
        step_cycle();
        RETRY = 1'b0;
        check_output("retry_restart", 3'd0, 2'd0, 0, 0, 0, 0, 0);

        // Asynchronous reset while in RX release.
        do_reset(1, 1, 0, "rxrel_reset");
        repeat (14) step_cycle();
        check_output("rxrel_reached", 3'd4, 2'd0, 1, 1, 1, 0, 0);
        do_reset(1, 1, 0, "async_reset_mid_op");
        step_cycle();
        check_output("restart_state0", 3'd0, 2'd0, 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 "random_reset");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset(PLL_LOCK, TX_CLK_STABLE, RX_READY, "random_mid_reset");
            end
            if ($urandom_range(0, 39) == 0) PLL_LOCK      = ~PLL_LOCK;
            if ($urandom_range(0, 14) == 0) TX_CLK_STABLE = ~TX_CLK_STABLE;
            if ($urandom_range(0, 14) == 0) RX_READY      = ~RX_READY;
            RETRY = ($urandom_range(0, 7) == 0);
            step_cycle();
            check_model("random");
        end
        RETRY = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
